// File: rtl/reset_sequencer_pkg.sv
// Shared phase encoding and sizing helper for the reset sequencer slice.
package reset_seq_pkg;

  localparam int unsigned PHASEWIDTH = 3;

  typedef enum logic [PHASEWIDTH-1:0] {
    IDLE       = 3'd0,
    RESET_WAIT = 3'd1,
    RESET_SYNC = 3'd2,
    OPER_WAIT  = 3'd3,
    OPER_SYNC  = 3'd4,
    INIT_WAIT  = 3'd5,
    DONE       = 3'd6
  } reset_seq_state_t;

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the system-control area.
interface reset_sequencer_if #(
  parameter int unsigned CLOCKDOMAINS = 3
) ();
  import reset_seq_pkg::*;

  logic                    restart_req;
  logic [CLOCKDOMAINS-2:0] sync_ack;
  logic                    sync_rst_out;
  logic                    clk_en_out;
  logic                    init_out;
  logic [PHASEWIDTH-1:0]   phase;
  logic                    busy;
  logic [CLOCKDOMAINS-2:0] sync_err;

  modport master (
    input  restart_req, sync_ack,
    output sync_rst_out, clk_en_out, init_out, phase, busy, sync_err
  );

  modport slave (
    output restart_req, sync_ack,
    input  sync_rst_out, clk_en_out, init_out, phase, busy, sync_err
  );

endinterface

// File: rtl/reset_sequencer_sync_ack_collector.sv
// Sticky per-domain acknowledge capture, all-ready detect and sticky timeout flags.
module sync_ack_collector #(
  parameter int unsigned NUMACK = 2
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic              captureEn,
  input  logic              clearEn,
  input  logic              errEn,
  input  logic [NUMACK-1:0] ack,
  output logic              allReady_c,
  output logic [NUMACK-1:0] syncErr
);

  logic [NUMACK-1:0] captured;
  logic [NUMACK-1:0] seen;

  // An ack present this cycle counts even before it lands in the capture register.
  assign seen       = captured | ack;
  assign allReady_c = &seen;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      captured <= '0;
      syncErr  <= '0;
    end else begin
      if (clearEn) begin
        captured <= '0;
      end else if (captureEn) begin
        captured <= seen;
      end
      if (errEn) begin
        syncErr <= syncErr | ~seen;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Phase FSM driving reset / enable / init pulses with per-domain ack gating.
// Optional handshake timeout compiled in with `define RESETSEQ_TIMEOUT_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned RESETWAITCYCLES       = 625000,
  parameter int unsigned OPERATIONALWAITCYCLES = 25000,
  parameter int unsigned INITIALIZEWAITCYCLES  = 1024,
  parameter int unsigned CLOCKDOMAINS          = 3,
  parameter int unsigned SYNCTIMEOUTCYCLES     = 4096
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic              clk_en,
  reset_sequencer_if.master bus
);

  localparam int unsigned NUMACK = CLOCKDOMAINS - 1;
`ifdef RESETSEQ_TIMEOUT_EN
  localparam int unsigned TIMEOUTSPAN = SYNCTIMEOUTCYCLES;
`else
  // Timeout does not size the counter in this build.
  localparam int unsigned TIMEOUTSPAN = 0 * SYNCTIMEOUTCYCLES;
`endif
  localparam int unsigned MAXCOUNT = maxOf(maxOf(RESETWAITCYCLES, OPERATIONALWAITCYCLES),
                                           maxOf(INITIALIZEWAITCYCLES, TIMEOUTSPAN));
  localparam int unsigned CNTWIDTH = $clog2(MAXCOUNT + 1);

  reset_seq_state_t      state, stateNext;
  logic [CNTWIDTH-1:0]   count, countNext, syncCountNext;
  logic                  startPending, startPendingNext;
  logic                  rstPulse, rstPulseNext;
  logic                  clkEnPulse, clkEnPulseNext;
  logic                  initPulse, initPulseNext;
  logic                  busyReg, busyNext;
  logic                  inSync, timeoutHit, syncDone, allReady;
  logic                  captureEn, clearEn, errEn;

  assign inSync = (state == RESET_SYNC) || (state == OPER_SYNC);

`ifdef RESETSEQ_TIMEOUT_EN
  assign timeoutHit    = inSync && (count == CNTWIDTH'(SYNCTIMEOUTCYCLES - 1));
  assign syncCountNext = count + CNTWIDTH'(1);
`else
  assign timeoutHit    = 1'b0;
  assign syncCountNext = count;
`endif

  assign syncDone  = allReady | timeoutHit;
  assign captureEn = clk_en & inSync;
  assign clearEn   = clk_en & (bus.restart_req | (inSync & syncDone));
  assign errEn     = clk_en & inSync & ~bus.restart_req & timeoutHit;

  sync_ack_collector #(.NUMACK(NUMACK)) ackCollector (
    .clk        (clk),
    .sync_rst   (sync_rst),
    .captureEn  (captureEn),
    .clearEn    (clearEn),
    .errEn      (errEn),
    .ack        (bus.sync_ack),
    .allReady_c (allReady),
    .syncErr    (bus.sync_err)
  );

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state        <= IDLE;
      count        <= '0;
      startPending <= 1'b1;
      rstPulse     <= 1'b0;
      clkEnPulse   <= 1'b0;
      initPulse    <= 1'b0;
      busyReg      <= 1'b0;
    end else begin
      state        <= stateNext;
      count        <= countNext;
      startPending <= startPendingNext;
      rstPulse     <= rstPulseNext;
      clkEnPulse   <= clkEnPulseNext;
      initPulse    <= initPulseNext;
      busyReg      <= busyNext;
    end
  end

  // Restart outranks expiry and ack completion; clk_en=0 freezes everything.
  always_comb begin
    stateNext        = state;
    countNext        = count;
    startPendingNext = startPending;
    rstPulseNext     = rstPulse;
    clkEnPulseNext   = clkEnPulse;
    initPulseNext    = initPulse;
    if (clk_en) begin
      rstPulseNext   = 1'b0;
      clkEnPulseNext = 1'b0;
      initPulseNext  = 1'b0;
      if (bus.restart_req) begin
        stateNext        = RESET_WAIT;
        countNext        = '0;
        startPendingNext = 1'b0;
      end else begin
        case (state)
          IDLE: if (startPending) begin
            stateNext        = RESET_WAIT;
            countNext        = '0;
            startPendingNext = 1'b0;
          end
          RESET_WAIT: if (count == CNTWIDTH'(RESETWAITCYCLES - 1)) begin
            stateNext    = RESET_SYNC;
            countNext    = '0;
            rstPulseNext = 1'b1;
          end else countNext = count + CNTWIDTH'(1);
          RESET_SYNC: if (syncDone) begin
            stateNext = OPER_WAIT;
            countNext = '0;
          end else countNext = syncCountNext;
          OPER_WAIT: if (count == CNTWIDTH'(OPERATIONALWAITCYCLES - 1)) begin
            stateNext      = OPER_SYNC;
            countNext      = '0;
            clkEnPulseNext = 1'b1;
          end else countNext = count + CNTWIDTH'(1);
          OPER_SYNC: if (syncDone) begin
            stateNext = INIT_WAIT;
            countNext = '0;
          end else countNext = syncCountNext;
          INIT_WAIT: if (count == CNTWIDTH'(INITIALIZEWAITCYCLES - 1)) begin
            stateNext     = DONE;
            countNext     = '0;
            initPulseNext = 1'b1;
          end else countNext = count + CNTWIDTH'(1);
          DONE: ;
          default: begin
            stateNext = IDLE;
            countNext = '0;
          end
        endcase
      end
    end
    busyNext = (stateNext != IDLE) && (stateNext != DONE);
  end

  assign bus.phase        = state;
  assign bus.busy         = busyReg;
  assign bus.sync_rst_out = rstPulse;
  assign bus.clk_en_out   = clkEnPulse;
  assign bus.init_out     = initPulse;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed + randomized bench for reset_sequencer against a phase-duration reference model.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int unsigned RW = 4;
  localparam int unsigned OW = 3;
  localparam int unsigned IW = 2;
  localparam int unsigned CD = 3;
`ifdef RESETSEQ_TIMEOUT_EN
  localparam int TO = 8;
`endif

  logic clk = 1'b0;
  logic sync_rst;
  logic clk_en;
  always #5 clk = ~clk;

  reset_sequencer_if #(.CLOCKDOMAINS(CD)) bus ();

  reset_sequencer #(
    .RESETWAITCYCLES       (RW),
    .OPERATIONALWAITCYCLES (OW),
    .INITIALIZEWAITCYCLES  (IW),
    .CLOCKDOMAINS          (CD),
    .SYNCTIMEOUTCYCLES     (8)
  ) dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .clk_en   (clk_en),
    .bus      (bus)
  );

  int nCompared   = 0;
  int nMismatched = 0;
  int cycleNo     = 0;

  // Reference model: phase number, enabled cycles spent in it, acks seen so far.
  int         mPhase   = 0;
  int         mElapsed = 0;
  logic [1:0] mGot     = '0;
  logic [1:0] mErr     = '0;
  logic       mRstP = 1'b0, mClkP = 1'b0, mInitP = 1'b0;

  function automatic int durOf(input int ph);
    case (ph)
      1: return RW;
      3: return OW;
      5: return IW;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s @cycle %0d observed=%0h expected=%0h", tag, cycleNo, obs, exp);
    end
  endtask

  task automatic modelStep(input logic rst, input logic en, input logic rq, input logic [1:0] ack);
    logic [1:0] have;
    if (rst) begin
      mPhase = 0; mElapsed = 0; mGot = '0; mErr = '0;
      mRstP = 1'b0; mClkP = 1'b0; mInitP = 1'b0;
    end else if (en) begin
      mRstP = 1'b0; mClkP = 1'b0; mInitP = 1'b0;
      if (rq) begin
        mPhase = 1; mElapsed = 0; mGot = '0;
      end else begin
        case (mPhase)
          0: begin mPhase = 1; mElapsed = 0; end
          1, 3, 5: begin
            mElapsed++;
            if (mElapsed == durOf(mPhase)) begin
              if (mPhase == 1) mRstP = 1'b1;
              else if (mPhase == 3) mClkP = 1'b1;
              else mInitP = 1'b1;
              mPhase   = (mPhase == 5) ? 6 : mPhase + 1;
              mElapsed = 0;
            end
          end
          2, 4: begin
            have = mGot | ack;
            mElapsed++;
            if (have == 2'b11) begin
              mPhase++; mGot = '0; mElapsed = 0;
            end
`ifdef RESETSEQ_TIMEOUT_EN
            else if (mElapsed == TO) begin
              mErr = mErr | ~have;
              mPhase++; mGot = '0; mElapsed = 0;
            end
`endif
            else mGot = have;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic checkAll();
    check("phase",        32'(bus.phase),        32'(mPhase));
    check("busy",         32'(bus.busy),         32'(mPhase != 0 && mPhase != 6));
    check("sync_rst_out", 32'(bus.sync_rst_out), 32'(mRstP));
    check("clk_en_out",   32'(bus.clk_en_out),   32'(mClkP));
    check("init_out",     32'(bus.init_out),     32'(mInitP));
    check("sync_err",     32'(bus.sync_err),     32'(mErr));
  endtask

  // Drive at negedge, model the edge, sample #1 after it.
  task automatic step(input logic rst, input logic en, input logic rq, input logic [1:0] ack);
    sync_rst        = rst;
    clk_en          = en;
    bus.restart_req = rq;
    bus.sync_ack    = ack;
    @(posedge clk);
    modelStep(rst, en, rq, ack);
    #1;
    cycleNo++;
    checkAll();
    @(negedge clk);
  endtask

  task automatic resetDut();
    step(1'b1, 1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b0, 1'b1, 2'b11);
  endtask

  initial begin
    int eRst, eClk, eInit, nRstHigh;
    logic en;
    sync_rst = 1'b1; clk_en = 1'b0; bus.restart_req = 1'b0; bus.sync_ack = '0;
    @(negedge clk);

    // Power-on, acks tied high: pulses after edges 4, 8, 11.
    resetDut();
    eRst = -1; eClk = -1; eInit = -1; nRstHigh = 0;
    for (int e = 0; e < 14; e++) begin
      step(1'b0, 1'b1, 1'b0, 2'b11);
      if (bus.sync_rst_out) begin nRstHigh++; if (eRst < 0) eRst = e; end
      if (bus.clk_en_out && eClk < 0) eClk = e;
      if (bus.init_out && eInit < 0) eInit = e;
    end
    check("pon_rst_edge",  32'(eRst), 32'(4));
    check("pon_clk_edge",  32'(eClk), 32'(8));
    check("pon_init_edge", 32'(eInit), 32'(11));
    check("pon_rst_width", 32'(nRstHigh), 32'(1));
    check("pon_phase_end", 32'(bus.phase), 32'(6));

    // clk_en toggling 1,0: event times double, pulses span one enabled cycle.
    resetDut();
    eRst = -1; eClk = -1; eInit = -1; nRstHigh = 0;
    for (int e = 0; e < 28; e++) begin
      en = (e % 2 == 0);
      step(1'b0, en, 1'b0, 2'b11);
      if (bus.sync_rst_out) begin nRstHigh++; if (eRst < 0) eRst = e; end
      if (bus.clk_en_out && eClk < 0) eClk = e;
      if (bus.init_out && eInit < 0) eInit = e;
    end
    check("tog_rst_edge",  32'(eRst), 32'(8));
    check("tog_clk_edge",  32'(eClk), 32'(16));
    check("tog_init_edge", 32'(eInit), 32'(22));
    check("tog_rst_width", 32'(nRstHigh), 32'(2));

    // Domain 1 ack pulses once at edge 10 during RESET_SYNC.
    resetDut();
    for (int e = 0; e < 17; e++) begin
      step(1'b0, 1'b1, 1'b0, (e == 10) ? 2'b11 : 2'b01);
      if (e == 9)  check("ack_wait_phase", 32'(bus.phase), 32'(2));
      if (e == 10) check("ack_adv_phase",  32'(bus.phase), 32'(3));
    end
    check("ack_cleared_stuck", 32'(bus.phase), 32'(4));

    // Restart while OPER_WAIT counter is 1, then the sequence repeats.
    resetDut();
    for (int e = 0; e < 7; e++) step(1'b0, 1'b1, 1'b0, 2'b11);
    step(1'b0, 1'b1, 1'b1, 2'b11);
    check("rq_phase", 32'(bus.phase), 32'(1));
    eRst = -1;
    for (int e = 8; e < 20; e++) begin
      step(1'b0, 1'b1, 1'b0, 2'b11);
      if (bus.sync_rst_out && eRst < 0) eRst = e;
    end
    check("rq_rst_edge", 32'(eRst), 32'(11));

    // Acks never arrive.
    resetDut();
    for (int e = 0; e < 14; e++) step(1'b0, 1'b1, 1'b0, 2'b00);
`ifdef RESETSEQ_TIMEOUT_EN
    check("to_phase", 32'(bus.phase), 32'(3));
    check("to_err",   32'(bus.sync_err), 32'(2'b11));
`else
    check("to_phase", 32'(bus.phase), 32'(2));
    check("to_err",   32'(bus.sync_err), 32'(2'b00));
`endif

    // sync_rst together with restart_req mid-INIT_WAIT.
    resetDut();
    for (int e = 0; e < 11; e++) step(1'b0, 1'b1, 1'b0, 2'b11);
    check("mid_init_phase", 32'(bus.phase), 32'(5));
    step(1'b1, 1'b1, 1'b1, 2'b11);
    check("rst_phase", 32'(bus.phase), 32'(0));
    check("rst_busy",  32'(bus.busy), 32'(0));
    eRst = -1;
    for (int e = 0; e < 6; e++) begin
      step(1'b0, 1'b1, 1'b0, 2'b11);
      if (bus.sync_rst_out && eRst < 0) eRst = e;
    end
    check("rerun_rst_edge", 32'(eRst), 32'(4));

    // Randomized traffic against the model.
    resetDut();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 3,
           ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on and restart sequencer for the system-control area. It generalises the fixed reset → operational → initialise countdown into a phase FSM with per-domain acknowledge handshakes, restart requests, phase visibility and optional handshake timeout. It drives the design-wide `sync_rst_out`, `clk_en_out` and `init_out` pulses, and collects ready acknowledges from the other clock domains between phases.

## Interface
- `RESETWAITCYCLES`, default 625000: enabled cycles spent in RESET_WAIT; must be ≥1.
- `OPERATIONALWAITCYCLES`, default 25000: enabled cycles spent in OPER_WAIT; must be ≥1.
- `INITIALIZEWAITCYCLES`, default 1024: enabled cycles spent in INIT_WAIT; must be ≥1.
- `CLOCKDOMAINS`, default 3: domain count including the local domain; must be ≥2.
- `SYNCTIMEOUTCYCLES`, default 4096: enabled cycles a SYNC state waits before timing out. Used only with `RESETSEQ_TIMEOUT_EN`.
- `clk` input 1: the single clock.
- `sync_rst` input 1: reset, synchronous and active-high.
- `clk_en` input 1: cycle qualifier. All state advances only when this is 1.
- `restart_req` input 1: restarts the sequence. Sampled only when `clk_en`=1.
- `sync_ack` input [CLOCKDOMAINS-2:0]: per-domain ready acknowledges, already synchronised into `clk`.
- `sync_rst_out` output 1: reset pulse to the rest of the design.
- `clk_en_out` output 1: operational-enable pulse.
- `init_out` output 1: initialise pulse.
- `phase` output 3: current state encoding.
- `busy` output 1: high when the state is neither IDLE nor DONE.
- `sync_err` output [CLOCKDOMAINS-2:0]: sticky per-domain timeout flags.

## Operation
- **State encodings (`phase`):** IDLE=0, RESET_WAIT=1, RESET_SYNC=2, OPER_WAIT=3, OPER_SYNC=4, INIT_WAIT=5, DONE=6.
- **Reset values:** state=IDLE, counter=0, all captured acks=0, every output=0, start_pending=1.
- **Start:** IDLE with start_pending=1 and `clk_en`=1 → RESET_WAIT with counter=0. start_pending then clears.
- **WAIT states:** the counter increments on each `clk_en` cycle. When counter==N-1 with `clk_en`=1, the FSM moves to the next SYNC state (or to DONE from INIT_WAIT) and the counter resets to 0. Each WAIT state therefore lasts exactly N enabled cycles.
- **Counter width:** $clog2 of the maximum of all phase counts plus 1. `SYNCTIMEOUTCYCLES` is included in that maximum when the timeout is compiled in. The counter never wraps.
- **SYNC states:** each `sync_ack` bit is captured sticky on `clk_en` cycles. The local domain counts as always ready. The FSM leaves the SYNC state on the first `clk_en` cycle where (captured | `sync_ack`) is all-ones. On leaving, all captured bits clear. A SYNC state lasts at least 1 cycle.
- **Transitions:** RESET_SYNC→OPER_WAIT, OPER_SYNC→INIT_WAIT, INIT_WAIT→DONE.
- **DONE:** holds until `restart_req` arrives.
- **Pulses:**
  - `sync_rst_out` sets on the RESET_WAIT→RESET_SYNC transition.
  - `clk_en_out` sets on the OPER_WAIT→OPER_SYNC transition.
  - `init_out` sets on the INIT_WAIT→DONE transition.
  - Each pulse clears at the next `clk_en`=1 edge, so it covers exactly one enabled cycle.
- **Restart:** `restart_req`=1 with `clk_en`=1 in any state, including mid-sequence, → RESET_WAIT with counter=0. It also clears captured acks and pending pulses. `sync_err` is not cleared.
- **Priorities:**
  - `sync_rst` beats everything.
  - `restart_req` beats phase expiry and ack completion in the same cycle.
  - An ack arriving on the timeout cycle counts as received.

## Timing
- All outputs are registered. There are no combinational input→output paths.
- Edge 0 is the first edge with `sync_rst`=0 and `clk_en`=1. With `clk_en` tied to 1 and acks tied to 1:
  - edge 4: enter RESET_SYNC; `sync_rst_out` is high for the following cycle.
  - edge 5: enter OPER_WAIT.
  - edge 8: enter OPER_SYNC; `clk_en_out` is high.
  - edge 9: enter INIT_WAIT.
  - edge 11: enter DONE; `init_out` is high for one cycle.
- This timeline uses RESETWAITCYCLES=4, OPERATIONALWAITCYCLES=3, INITIALIZEWAITCYCLES=2.
- With `clk_en`=0 everything freezes: state, counter, captured acks and pulse levels.

## Configuration
- `RESETSEQ_TIMEOUT_EN` defined:
  - The counter runs in SYNC states.
  - At counter==SYNCTIMEOUTCYCLES-1, each missing domain sets its `sync_err` bit and the FSM advances as if all domains had acknowledged.
  - `sync_err` clears only on `sync_rst`.
- `RESETSEQ_TIMEOUT_EN` undefined:
  - SYNC states wait indefinitely.
  - `sync_err` is tied to 0.
  - `SYNCTIMEOUTCYCLES` is unused.

## Structure
- Package `reset_seq_pkg` holds:
  - the `reset_seq_state_t` enum with the phase encodings above;
  - the `PHASEWIDTH`=3 constant.
- Sub-module `sync_ack_collector` holds the per-domain sticky capture, the all-ready detect, the clear, and the timeout error logic. The parent owns the FSM, counter and pulses.

## Test plan
All scenarios use the parameters 4/3/2, CLOCKDOMAINS=3, SYNCTIMEOUTCYCLES=8.
- **Power-on, acks tied 1, `clk_en`=1:** `sync_rst_out` high after edge 4, `clk_en_out` after edge 8, `init_out` after edge 11, each for 1 cycle. `phase` ends at 6 and `busy`=0.
- **`clk_en` toggling 1,0:** every event time doubles, and each pulse spans exactly one enabled cycle.
- **Ack held low in RESET_SYNC:** `sync_ack`=2'b01 stays, and bit1 pulses once at cycle 10. OPER_WAIT is entered on that same edge, and captured acks read 0 afterwards.
- **`restart_req` on OPER_WAIT counter=1:** next `phase`=1 with counter 0, and the full sequence repeats.
- **Timeout build:** `sync_ack`=0 forever. After 8 enabled cycles in RESET_SYNC, `sync_err`=2'b11 and the FSM reaches OPER_WAIT. Without the macro, `phase` stays at 2 indefinitely.
- **`sync_rst` asserted mid-INIT_WAIT together with `restart_req`:** all outputs read 0, `phase`=0, and the sequence restarts from edge 0.
